alu_muldiv_seq: RTL and testbench

//  Iterative MULT/MULTU/DIV/DIVU unit that drives the 32-bit ALU through its ADD/SUB/SLTU ops, one step per clock.

---
 rtl/alu_muldiv_seq_pkg.sv | 30 +++
 rtl/alu_muldiv_seq_alu.sv | 24 ++
 rtl/alu_muldiv_seq.sv | 219 +++++++++++++++++++++
 tb/tb_alu_muldiv_seq.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_muldiv_seq_pkg.sv
// Shared definitions for the iterative multiply/divide sequencer and its ALU.
package alu_muldiv_seq_pkg;

   // ALU operation codes understood by the execute-stage ALU
   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_SLTU = 4'b0100;

   // Multiply/divide operation encodings (bit 1: divide, bit 0: signed)
   localparam logic [1:0] MD_MULTU = 2'b00;
   localparam logic [1:0] MD_MULT  = 2'b01;
   localparam logic [1:0] MD_DIVU  = 2'b10;
   localparam logic [1:0] MD_DIV   = 2'b11;

   // Sequencer FSM state encodings
   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_PREP  = 3'd1;
   localparam logic [2:0] ST_ITER  = 3'd2;
   localparam logic [2:0] ST_FIXUP = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

   function automatic logic md_is_div(input logic [1:0] md_op);
      return md_op[1];
   endfunction

   function automatic logic md_is_signed(input logic [1:0] md_op);
      return md_op[0];
   endfunction

endpackage

// File: rtl/alu_muldiv_seq_alu.sv
// Execute-stage integer ALU (subset used by the multiply/divide sequencer).
module alu
   import alu_muldiv_seq_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic [3:0]       op,
   output logic [WIDTH-1:0] result
);

   // Operation select; unsupported codes produce zero
   always_comb begin
      result = '0;
      case (op)
         ALU_ADD:  result = in1 + in2;
         ALU_SUB:  result = in1 - in2;
         ALU_SLTU: result = {{(WIDTH-1){1'b0}}, (in1 < in2)};
         default:  result = '0;
      endcase
   end

endmodule

// File: rtl/alu_muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU unit: one shift-add / restoring-divide step
// per clock through the shared ALU, results delivered in HI/LO.
module alu_muldiv_seq
   import alu_muldiv_seq_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] rs,
   input  logic [WIDTH-1:0] rt,
   input  logic             cancel,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   logic [2:0]       state;
   logic [2:0]       state_nx;
   logic [CNT_W-1:0] cnt;

   logic [1:0]       op_q;
   logic [WIDTH-1:0] rs_q;
   logic [WIDTH-1:0] rt_q;
   logic             sign_a;
   logic             sign_b;

   // acc_hi/acc_lo double as remainder/quotient for divides; mcand holds the divisor
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] acc_hi;
   logic [WIDTH-1:0] acc_lo;

   logic [WIDTH-1:0] hi_q;
   logic [WIDTH-1:0] lo_q;
   logic             dbz_q;

   logic             is_div;
   logic             accept;
   logic             div_zero;
   logic             rs_neg;
   logic             rt_neg;
   logic [WIDTH-1:0] rs_abs;
   logic [WIDTH-1:0] rt_abs;

   logic [3:0]       alu_op;
   logic [WIDTH-1:0] alu_in1;
   logic [WIDTH-1:0] alu_in2;
   logic [WIDTH-1:0] alu_res;

   logic [WIDTH-1:0] rem_sh;
   logic             out_bit;
   logic             rem_lt;
   logic             step_en;
   logic             carry;
   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] step_hi;
   logic [WIDTH-1:0] step_lo;

   logic [2*WIDTH-1:0] prod;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   fix_hi;
   logic [WIDTH-1:0]   fix_lo;

   assign is_div   = md_is_div(op_q);
   assign accept   = (state == ST_IDLE) && start && !cancel;
   assign div_zero = is_div && (rt_q == '0);

   assign rs_neg = md_is_signed(op_q) && rs_q[WIDTH-1];
   assign rt_neg = md_is_signed(op_q) && rt_q[WIDTH-1];
   assign rs_abs = rs_neg ? ('0 - rs_q) : rs_q;
   assign rt_abs = rt_neg ? ('0 - rt_q) : rt_q;

   assign rem_sh  = {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]};
   assign out_bit = acc_hi[WIDTH-1];
   // Unsigned compare with the same semantics as ALU SLTU
   assign rem_lt  = (rem_sh < mcand);

   assign alu_op  = is_div ? ALU_SUB : ALU_ADD;
   assign alu_in1 = is_div ? rem_sh : acc_hi;
   assign alu_in2 = mcand;

   alu #(.WIDTH(WIDTH)) u_alu (
      .in1    (alu_in1),
      .in2    (alu_in2),
      .op     (alu_op),
      .result (alu_res)
   );

   // One iteration step: shift-add multiply or restoring divide
   always_comb begin
      step_en = 1'b0;
      carry   = 1'b0;
      sum     = acc_hi;
      step_hi = acc_hi;
      step_lo = acc_lo;
      if (is_div) begin
         step_en = out_bit || !rem_lt;
         step_hi = step_en ? alu_res : rem_sh;
         step_lo = {acc_lo[WIDTH-2:0], step_en};
      end else begin
         step_en = acc_lo[0];
         sum     = step_en ? alu_res : acc_hi;
         carry   = step_en && (alu_res < mcand);
         step_hi = {carry, sum[WIDTH-1:1]};
         step_lo = {sum[0], acc_lo[WIDTH-1:1]};
      end
   end

   // Sign correction applied to the magnitude result
   always_comb begin
      prod     = {acc_hi, acc_lo};
      prod_fix = (sign_a ^ sign_b) ? ('0 - prod) : prod;
      if (is_div) begin
         fix_lo = (sign_a ^ sign_b) ? ('0 - acc_lo) : acc_lo;
         fix_hi = sign_a ? ('0 - acc_hi) : acc_hi;
      end else begin
         fix_lo = prod_fix[WIDTH-1:0];
         fix_hi = prod_fix[2*WIDTH-1:WIDTH];
      end
   end

   // Next-state logic; cancel overrides every non-idle transition
   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:  if (accept) state_nx = ST_PREP;
         ST_PREP:  state_nx = div_zero ? ST_DONE : ST_ITER;
         ST_ITER:  if (cnt == CNT_LAST) state_nx = ST_FIXUP;
         ST_FIXUP: state_nx = ST_DONE;
         ST_DONE:  state_nx = ST_IDLE;
         default:  state_nx = ST_IDLE;
      endcase
      if (state != ST_IDLE && cancel) state_nx = ST_IDLE;
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nx;
   end

   // Operand latch, sign capture, iteration counter and accumulators
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q   <= '0;
         rs_q   <= '0;
         rt_q   <= '0;
         sign_a <= 1'b0;
         sign_b <= 1'b0;
         mcand  <= '0;
         acc_hi <= '0;
         acc_lo <= '0;
         cnt    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  op_q <= op;
                  rs_q <= rs;
                  rt_q <= rt;
               end
            end
            ST_PREP: begin
               cnt    <= '0;
               sign_a <= rs_neg;
               sign_b <= rt_neg;
               acc_hi <= '0;
               if (is_div) begin
                  acc_lo <= rs_abs;
                  mcand  <= rt_abs;
               end else begin
                  acc_lo <= rt_abs;
                  mcand  <= rs_abs;
               end
            end
            ST_ITER: begin
               cnt    <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
               acc_hi <= step_hi;
               acc_lo <= step_lo;
            end
            default: ;
         endcase
      end
   end

   // Architectural HI/LO and divide-by-zero flag; a cancelled op never writes them
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi_q  <= '0;
         lo_q  <= '0;
         dbz_q <= 1'b0;
      end else begin
         if (accept) dbz_q <= 1'b0;
         if (state == ST_PREP && div_zero && !cancel) begin
            hi_q  <= rs_q;
            lo_q  <= '1;
            dbz_q <= 1'b1;
         end
         if (state == ST_FIXUP && !cancel) begin
            hi_q <= fix_hi;
            lo_q <= fix_lo;
         end
      end
   end

   assign busy        = (state != ST_IDLE);
   assign done        = (state == ST_DONE);
   assign div_by_zero = dbz_q;
   assign hi          = hi_q;
   assign lo          = lo_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Self-checking bench for alu_muldiv_seq: directed table, corner sequences
// and random operations compared against an arithmetic reference model.
module tb_alu_muldiv_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [1:0]  op;
   logic [31:0] rs;
   logic [31:0] rt;
   logic        cancel;
   logic        busy;
   logic        done;
   logic        div_by_zero;
   logic [31:0] hi;
   logic [31:0] lo;

   int checks = 0;
   int errors = 0;

   alu_muldiv_seq #(.WIDTH(32), .CNT_W(6)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .op          (op),
      .rs          (rs),
      .rt          (rt),
      .cancel      (cancel),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero),
      .hi          (hi),
      .lo          (lo)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] eh;
      logic [31:0] el;
      logic        ez;
   } vec_t;

   vec_t vecs[8];

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", name, act, exp);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%b exp=%b", name, act, exp);
      end
   endtask

   // Reference: plain 64-bit arithmetic on the operands' mathematical values
   function automatic void model(input logic [1:0] mop, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] eh, output logic [31:0] el, output logic ez);
      logic [63:0]        up;
      logic signed [63:0] sp;
      longint             sa;
      longint             sb;
      ez = 1'b0;
      eh = '0;
      el = '0;
      case (mop)
         2'b00: begin
            up = {32'b0, a} * {32'b0, b};
            eh = up[63:32];
            el = up[31:0];
         end
         2'b01: begin
            sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            eh = sp[63:32];
            el = sp[31:0];
         end
         default: begin
            if (b == 32'd0) begin
               eh = a;
               el = 32'hFFFF_FFFF;
               ez = 1'b1;
            end else if (mop == 2'b10) begin
               el = a / b;
               eh = a % b;
            end else begin
               sa = longint'($signed(a));
               sb = longint'($signed(b));
               el = 32'(sa / sb);
               eh = 32'(sa % sb);
            end
         end
      endcase
   endfunction

   // Present a request so that it is sampled at the next rising edge (edge 0)
   task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      op    = o;
      rs    = a;
      rt    = b;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // Bounded wait for done; lat is the cycle index of done, 0 on timeout
   task automatic wait_done(input int k0, output int lat, output logic busy_ok);
      lat     = 0;
      busy_ok = 1'b1;
      for (int k = k0; k < 80; k++) begin
         @(negedge clk);
         if (!busy) busy_ok = 1'b0;
         if (done) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic run_vec(input string name, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                          input logic ez);
      int   lat;
      logic bok;
      issue(o, a, b);
      check1({name, "_dbz_clr"}, div_by_zero, 1'b0);
      wait_done(1, lat, bok);
      check32({name, "_lat"}, 32'(lat), ez ? 32'd2 : 32'd35);
      check1({name, "_busy"}, bok, 1'b1);
      check32({name, "_hi"}, hi, eh);
      check32({name, "_lo"}, lo, el);
      check1({name, "_dbz"}, div_by_zero, ez);
      @(negedge clk);
      check1({name, "_done_pulse"}, done, 1'b0);
      check1({name, "_idle"}, busy, 1'b0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          lat;
      int          n_done;
      logic        bok;
      logic [31:0] eh;
      logic [31:0] el;
      logic        ez;
      logic [31:0] a;
      logic [31:0] b;
      logic [1:0]  o;
      logic [31:0] old_hi;
      logic [31:0] old_lo;
      logic [31:0] corner[4];

      corner = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0001};

      vecs[0] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
      vecs[1] = '{2'b01, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
      vecs[2] = '{2'b11, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
      vecs[3] = '{2'b10, 32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF, 1'b1};
      vecs[4] = '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
      vecs[5] = '{2'b10, 32'hFFFF_FFFF, 32'd1,         32'h0000_0000, 32'hFFFF_FFFF, 1'b0};
      vecs[6] = '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
      vecs[7] = '{2'b00, 32'd6,         32'd7,         32'd0,         32'd42,        1'b0};

      rst_n  = 1'b1;
      start  = 1'b0;
      cancel = 1'b0;
      op     = '0;
      rs     = '0;
      rt     = '0;
      #2 rst_n = 1'b0;
      #1;
      check1("rst_busy", busy, 1'b0);
      check1("rst_done", done, 1'b0);
      check1("rst_dbz", div_by_zero, 1'b0);
      check32("rst_hi", hi, 32'd0);
      check32("rst_lo", lo, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Directed table
      for (int i = 0; i < 8; i++)
         run_vec($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                 vecs[i].eh, vecs[i].el, vecs[i].ez);

      // Start during DONE is ignored; start one cycle later is accepted
      issue(2'b00, 32'd3, 32'd5);
      wait_done(1, lat, bok);
      check32("b2b_first_lo", lo, 32'd15);
      start = 1'b1;
      op    = 2'b00;
      rs    = 32'd9;
      rt    = 32'd9;
      @(posedge clk);
      #1 check1("b2b_ignored", busy, 1'b0);
      @(posedge clk);
      #1 start = 1'b0;
      check1("b2b_accepted", busy, 1'b1);
      wait_done(1, lat, bok);
      check32("b2b_lat", 32'(lat), 32'd35);
      check32("b2b_lo", lo, 32'd81);

      // Start pulsed at cycle 10 of a running op is ignored
      issue(2'b00, 32'h0000_1234, 32'h0000_5678);
      repeat (9) @(posedge clk);
      #1;
      start = 1'b1;
      op    = 2'b11;
      rs    = 32'h1111_1111;
      rt    = 32'd3;
      @(posedge clk);
      #1 start = 1'b0;
      wait_done(11, lat, bok);
      check32("ign_lat", 32'(lat), 32'd35);
      check32("ign_hi", hi, 32'd0);
      check32("ign_lo", lo, 32'h0626_0060);
      @(negedge clk);
      check1("ign_no_restart", busy, 1'b0);

      // Cancel at cycle 20: back to IDLE, no done, HI/LO untouched
      old_hi = hi;
      old_lo = lo;
      issue(2'b10, 32'hDEAD_BEEF, 32'd7);
      repeat (19) @(posedge clk);
      #1 cancel = 1'b1;
      @(posedge clk);
      #1 cancel = 1'b0;
      check1("cancel_idle", busy, 1'b0);
      n_done = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (done) n_done++;
      end
      check32("cancel_no_done", 32'(n_done), 32'd0);
      check32("cancel_hi", hi, old_hi);
      check32("cancel_lo", lo, old_lo);

      // Cancel together with start in IDLE drops the start
      @(negedge clk);
      start  = 1'b1;
      cancel = 1'b1;
      @(posedge clk);
      #1;
      start  = 1'b0;
      cancel = 1'b0;
      check1("cancel_start_idle", busy, 1'b0);

      // Randomized operations against the reference model
      for (int i = 0; i < 40; i++) begin
         o = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 3))
            0:       a = $urandom;
            1:       a = 32'($urandom_range(0, 50));
            2:       a = corner[$urandom_range(0, 3)];
            default: a = 32'(-int'($urandom_range(1, 100)));
         endcase
         case ($urandom_range(0, 4))
            0:       b = $urandom;
            1:       b = 32'($urandom_range(1, 50));
            2:       b = corner[$urandom_range(0, 3)];
            3:       b = 32'(-int'($urandom_range(1, 100)));
            default: b = (o[1] && $urandom_range(0, 1) == 0) ? 32'd0 : $urandom;
         endcase
         model(o, a, b, eh, el, ez);
         run_vec($sformatf("rnd%0d_op%0d_%h_%h", i, o, a, b), o, a, b, eh, el, ez);
      end

      // Asynchronous reset mid-ITER, between clock edges
      issue(2'b00, 32'hFFFF_FFFF, 32'h1234_5678);
      repeat (14) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check1("arst_busy", busy, 1'b0);
      check1("arst_done", done, 1'b0);
      check1("arst_dbz", div_by_zero, 1'b0);
      check32("arst_hi", hi, 32'd0);
      check32("arst_lo", lo, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_vec("post_rst", 2'b00, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
